// File: rtl/branch_predictor.sv
// 2-bit saturating-counter BHT indexed by pc[INDEX_BITS+1:2], plus branch and mispredict counters for CSR readout.
// The lookup is a zero-latency combinational read. Updates land on the next rising edge unless stall is high.
module branch_predictor #(
  parameter int INDEX_BITS = 5,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          pc_if,
  output logic                 pred_taken_if,
  input  logic                 stall,
  input  logic                 is_branch_id,
  input  logic [31:0]          pc_id,
  input  logic                 pred_taken_id,
  input  logic                 branch_taken_id,
  output logic                 mispredict,
  output logic [CNT_WIDTH-1:0] branch_cnt,
  output logic [CNT_WIDTH-1:0] mispredict_cnt
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [ENTRIES-1:0][1:0] r_bht;
  logic [CNT_WIDTH-1:0]    r_branch_cnt;
  logic [CNT_WIDTH-1:0]    r_mispredict_cnt;

  logic [INDEX_BITS-1:0]   w_if_idx;
  logic [INDEX_BITS-1:0]   w_id_idx;
  logic [1:0]              w_cur;
  logic [1:0]              w_nxt;
  logic                    w_upd;
  logic                    w_unused_pc;

  assign w_if_idx = pc_if[INDEX_BITS+1:2];
  assign w_id_idx = pc_id[INDEX_BITS+1:2];

  // Tagless table: the PC bits outside the index window are deliberately ignored.
  assign w_unused_pc = ^{pc_if[31:INDEX_BITS+2], pc_if[1:0],
                         pc_id[31:INDEX_BITS+2], pc_id[1:0]};

  // Read-before-write: a same-cycle update to this index is not bypassed.
  assign pred_taken_if = r_bht[w_if_idx][1];

  assign mispredict = is_branch_id & (pred_taken_id ^ branch_taken_id);
  assign w_upd      = is_branch_id & ~stall;

  assign w_cur = r_bht[w_id_idx];

  always_comb begin
    w_nxt = w_cur;
    if (branch_taken_id) begin
      if (w_cur != 2'b11) w_nxt = w_cur + 2'd1;
    end else begin
      if (w_cur != 2'b00) w_nxt = w_cur - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bht            <= {ENTRIES{2'b01}};
      r_branch_cnt     <= '0;
      r_mispredict_cnt <= '0;
    end else if (w_upd) begin
      r_bht[w_id_idx] <= w_nxt;
      r_branch_cnt    <= r_branch_cnt + CNT_WIDTH'(1);
      if (mispredict) r_mispredict_cnt <= r_mispredict_cnt + CNT_WIDTH'(1);
    end
  end

  assign branch_cnt     = r_branch_cnt;
  assign mispredict_cnt = r_mispredict_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed vector table, hand-written reset sweeps, and random traffic against a behavioural model.
// A second instance with 3-bit counters shares every input so counter wrap-around is exercised quickly.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_if;
  logic        stall;
  logic        is_branch_id;
  logic [31:0] pc_id;
  logic        pred_taken_id;
  logic        branch_taken_id;

  logic        pred_taken_if;
  logic        mispredict;
  logic [31:0] branch_cnt;
  logic [31:0] mispredict_cnt;

  logic        sm_pred_taken_if;
  logic        sm_mispredict;
  logic [2:0]  sm_branch_cnt;
  logic [2:0]  sm_mispredict_cnt;

  always #5 clk = ~clk;

  branch_predictor #(.INDEX_BITS(5), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .pc_if(pc_if), .pred_taken_if(pred_taken_if),
    .stall(stall), .is_branch_id(is_branch_id), .pc_id(pc_id),
    .pred_taken_id(pred_taken_id), .branch_taken_id(branch_taken_id),
    .mispredict(mispredict), .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
  );

  branch_predictor #(.INDEX_BITS(5), .CNT_WIDTH(3)) u_small (
    .clk(clk), .rst(rst), .pc_if(pc_if), .pred_taken_if(sm_pred_taken_if),
    .stall(stall), .is_branch_id(is_branch_id), .pc_id(pc_id),
    .pred_taken_id(pred_taken_id), .branch_taken_id(branch_taken_id),
    .mispredict(sm_mispredict), .branch_cnt(sm_branch_cnt), .mispredict_cnt(sm_mispredict_cnt)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural model: each entry is a confidence level 0..3; "taken" means level >= 2.
  int          m_lvl [32];
  bit [31:0]   m_bcnt;
  bit [31:0]   m_mcnt;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % 32);
  endfunction

  function automatic logic m_pred(input logic [31:0] pc);
    return (m_lvl[idx_of(pc)] >= 2);
  endfunction

  function automatic logic m_misp();
    return is_branch_id && (pred_taken_id != branch_taken_id);
  endfunction

  task automatic model_step();
    int i;
    if (rst) begin
      for (int k = 0; k < 32; k++) m_lvl[k] = 1;
      m_bcnt = 0;
      m_mcnt = 0;
    end else if (is_branch_id && !stall) begin
      i = idx_of(pc_id);
      if (branch_taken_id) m_lvl[i] = (m_lvl[i] == 3) ? 3 : m_lvl[i] + 1;
      else                 m_lvl[i] = (m_lvl[i] == 0) ? 0 : m_lvl[i] - 1;
      if (pred_taken_id != branch_taken_id) m_mcnt = m_mcnt + 1;
      m_bcnt = m_bcnt + 1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic b, input logic [31:0] pif,
                       input logic [31:0] pid, input logic p, input logic t);
    rst = r; stall = s; is_branch_id = b; pc_if = pif; pc_id = pid;
    pred_taken_id = p; branch_taken_id = t;
  endtask

  typedef struct {
    logic        rst, stall, br;
    logic [31:0] pif, pid;
    logic        pred, tkn;
    logic        e_pred, e_misp;
    logic [31:0] e_b, e_m;
  } vec_t;

  vec_t vt [18];

  initial begin
    // Expected outputs are observed before the edge that applies this row's update.
    //          rst stall br  pc_if         pc_id         pred tkn  e_pred e_misp e_b e_m
    vt[0]  = '{1'b0, 1'b0, 1'b1, 32'h1010, 32'h1010, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0,  32'd0};
    vt[1]  = '{1'b0, 1'b0, 1'b1, 32'h1010, 32'h1010, 1'b0, 1'b1, 1'b1, 1'b1, 32'd1,  32'd1};
    vt[2]  = '{1'b0, 1'b0, 1'b1, 32'h1010, 32'h1010, 1'b0, 1'b1, 1'b1, 1'b1, 32'd2,  32'd2};
    vt[3]  = '{1'b0, 1'b0, 1'b1, 32'h1010, 32'h1010, 1'b0, 1'b1, 1'b1, 1'b1, 32'd3,  32'd3};
    vt[4]  = '{1'b0, 1'b0, 1'b1, 32'h1010, 32'h1010, 1'b1, 1'b0, 1'b1, 1'b1, 32'd4,  32'd4};
    vt[5]  = '{1'b0, 1'b0, 1'b1, 32'h1010, 32'h1010, 1'b1, 1'b0, 1'b1, 1'b1, 32'd5,  32'd5};
    vt[6]  = '{1'b0, 1'b0, 1'b1, 32'h1010, 32'h1010, 1'b1, 1'b0, 1'b0, 1'b1, 32'd6,  32'd6};
    vt[7]  = '{1'b0, 1'b0, 1'b0, 32'h1010, 32'h1010, 1'b1, 1'b0, 1'b0, 1'b0, 32'd7,  32'd7};
    vt[8]  = '{1'b0, 1'b0, 1'b1, 32'h2008, 32'h2008, 1'b0, 1'b1, 1'b0, 1'b1, 32'd7,  32'd7};
    vt[9]  = '{1'b0, 1'b0, 1'b0, 32'h2008, 32'h2008, 1'b0, 1'b1, 1'b1, 1'b0, 32'd8,  32'd8};
    vt[10] = '{1'b0, 1'b1, 1'b1, 32'h0004, 32'h0084, 1'b0, 1'b1, 1'b0, 1'b1, 32'd8,  32'd8};
    vt[11] = '{1'b0, 1'b0, 1'b0, 32'h0004, 32'h0084, 1'b0, 1'b1, 1'b0, 1'b0, 32'd8,  32'd8};
    vt[12] = '{1'b0, 1'b0, 1'b1, 32'h0004, 32'h0084, 1'b0, 1'b1, 1'b0, 1'b1, 32'd8,  32'd8};
    vt[13] = '{1'b0, 1'b0, 1'b0, 32'h0004, 32'h0084, 1'b0, 1'b1, 1'b1, 1'b0, 32'd9,  32'd9};
    vt[14] = '{1'b0, 1'b0, 1'b1, 32'h0004, 32'h0004, 1'b1, 1'b1, 1'b1, 1'b0, 32'd9,  32'd9};
    vt[15] = '{1'b0, 1'b0, 1'b0, 32'h0084, 32'h0004, 1'b1, 1'b1, 1'b1, 1'b0, 32'd10, 32'd9};
    vt[16] = '{1'b1, 1'b0, 1'b1, 32'h1010, 32'h1010, 1'b0, 1'b1, 1'b0, 1'b1, 32'd10, 32'd9};
    vt[17] = '{1'b0, 1'b0, 1'b0, 32'h0004, 32'h1010, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0,  32'd0};

    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clk); model_step();
    @(posedge clk); model_step();

    // Post-reset sweep: every entry predicts not-taken, counters cleared.
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 32'(i * 4), 32'h0, 1'b0, 1'b0);
      #1;
      chk($sformatf("reset_pred[%0d]", i), {31'b0, pred_taken_if}, 32'd0);
      @(posedge clk); model_step();
    end
    #1;
    chk("reset_branch_cnt", branch_cnt, 32'd0);
    chk("reset_mispredict_cnt", mispredict_cnt, 32'd0);

    for (int v = 0; v < 18; v++) begin
      @(negedge clk);
      drive(vt[v].rst, vt[v].stall, vt[v].br, vt[v].pif, vt[v].pid, vt[v].pred, vt[v].tkn);
      #1;
      chk($sformatf("vec%0d_pred", v), {31'b0, pred_taken_if}, {31'b0, vt[v].e_pred});
      chk($sformatf("vec%0d_misp", v), {31'b0, mispredict}, {31'b0, vt[v].e_misp});
      chk($sformatf("vec%0d_bcnt", v), branch_cnt, vt[v].e_b);
      chk($sformatf("vec%0d_mcnt", v), mispredict_cnt, vt[v].e_m);
      chk($sformatf("vec%0d_small_bcnt", v), {29'b0, sm_branch_cnt}, {29'b0, vt[v].e_b[2:0]});
      @(posedge clk); model_step();
    end

    // Mid-sequence reset: all entries back to weak-NT, so one taken update flips any index.
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 32'(i * 4 + 32'h400), 32'h0, 1'b0, 1'b0);
      #1;
      chk($sformatf("rst2_pred[%0d]", i), {31'b0, pred_taken_if}, 32'd0);
      @(posedge clk); model_step();
    end

    // Three-bit instance wraps every eight branches.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b1, 32'h0, 32'(i * 4), 1'b0, 1'b0);
      #1;
      chk($sformatf("wrap_small_bcnt[%0d]", i), {29'b0, sm_branch_cnt}, 32'(i % 8));
      @(posedge clk); model_step();
    end
    #1;
    chk("wrap_small_bcnt_final", {29'b0, sm_branch_cnt}, 32'd1);

    // Random traffic over a small PC range so aliasing and collisions are frequent.
    for (int n = 0; n < 600; n++) begin
      logic [31:0] pif, pid;
      logic r, s, b, p, t;
      @(negedge clk);
      pif = 32'($urandom_range(0, 127)) << 2;
      pid = ($urandom_range(0, 3) == 0) ? pif : (32'($urandom_range(0, 127)) << 2);
      r = ($urandom_range(0, 99) == 0);
      s = ($urandom_range(0, 3) == 0);
      b = $urandom_range(0, 1) != 0;
      t = $urandom_range(0, 1) != 0;
      p = ($urandom_range(0, 2) == 0) ? !m_pred(pid) : m_pred(pid);
      drive(r, s, b, pif, pid, p, t);
      #1;
      chk($sformatf("rnd%0d_pred", n), {31'b0, pred_taken_if}, {31'b0, m_pred(pif)});
      chk($sformatf("rnd%0d_misp", n), {31'b0, mispredict}, {31'b0, m_misp()});
      chk($sformatf("rnd%0d_bcnt", n), branch_cnt, m_bcnt);
      chk($sformatf("rnd%0d_mcnt", n), mispredict_cnt, m_mcnt);
      chk($sformatf("rnd%0d_small_bcnt", n), {29'b0, sm_branch_cnt}, {29'b0, m_bcnt[2:0]});
      chk($sformatf("rnd%0d_small_mcnt", n), {29'b0, sm_mispredict_cnt}, {29'b0, m_mcnt[2:0]});
      @(posedge clk); model_step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
